// File: rtl/accumulator_ctrl_if.sv
// Command handshake bundle for accumulator_ctrl: valid/ready plus the
// command fields that are sampled on accept.
interface accumulator_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         cmd;
    logic [2:0]         alu_ctrl;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;

    modport master (
        output req_valid, cmd, alu_ctrl, operand, shamt,
        input  req_ready
    );

    modport slave (
        input  req_valid, cmd, alu_ctrl, operand, shamt,
        output req_ready
    );
endinterface

// File: rtl/accumulator_ctrl.sv
// Accumulator and C/V/Z flag stage around an external ALU: runs ALU writeback,
// LOAD, and serial one-bit-per-cycle logical shifts, one command per handshake.
module accumulator_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    accumulator_ctrl_if.slave  req,
    output logic [WIDTH-1:0]   alu_a_out,
    output logic [WIDTH-1:0]   alu_b_out,
    output logic [2:0]         alu_control_out,
    input  logic [WIDTH-1:0]   alu_sum_in,
    input  logic               alu_carry_in,
    input  logic               alu_overflow_in,
    input  logic               alu_zero_in,
    output logic [WIDTH-1:0]   acc_out,
    output logic               c_flag_out,
    output logic               v_flag_out,
    output logic               z_flag_out,
    output logic               busy_out,
    output logic               done_out
);
    localparam logic [1:0] CMD_ALU  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_SHR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic [1:0]         cmd_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         ctrl_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   acc_r;
    logic               c_r;
    logic               v_r;
    logic               z_r;
    logic               done_r;
    logic [WIDTH-1:0]   shift_acc_s;
    logic               shift_c_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] val);
        return (val == {WIDTH{1'b0}});
    endfunction

    // Next-state decode and accept qualification
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req.req_valid) begin
                    accept_s = 1'b1;
                    if (req.cmd[1] && (req.shamt != {SHAMT_W{1'b0}})) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_IDLE;
            ST_SHIFT: begin
                if (cnt_r == SHAMT_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // One-bit shift step; the bit shifted out becomes the carry
    always_comb begin
        shift_acc_s = {acc_r[WIDTH-2:0], 1'b0};
        shift_c_s   = acc_r[WIDTH-1];
        if (cmd_r == CMD_SHR) begin
            shift_acc_s = {1'b0, acc_r[WIDTH-1:1]};
            shift_c_s   = acc_r[0];
        end else begin
            shift_acc_s = {acc_r[WIDTH-2:0], 1'b0};
            shift_c_s   = acc_r[WIDTH-1];
        end
    end

    // State, command latches, accumulator and flag writeback
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_r <= ST_IDLE;
            cmd_r   <= 2'b00;
            b_r     <= {WIDTH{1'b0}};
            ctrl_r  <= 3'b000;
            cnt_r   <= {SHAMT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_r  <= req.cmd;
                        b_r    <= req.operand;
                        ctrl_r <= req.alu_ctrl;
                        cnt_r  <= req.shamt;
                    end else begin
                        cmd_r  <= cmd_r;
                    end
                end
                ST_EXEC: begin
                    done_r <= 1'b1;
                    case (cmd_r)
                        CMD_ALU: begin
                            acc_r <= alu_sum_in;
                            c_r   <= alu_carry_in;
                            v_r   <= alu_overflow_in;
                            z_r   <= alu_zero_in;
                        end
                        CMD_LOAD: begin
                            acc_r <= b_r;
                            z_r   <= is_zero(b_r);
                        end
                        // zero-count shifts retire with no writeback
                        default: acc_r <= acc_r;
                    endcase
                end
                ST_SHIFT: begin
                    cnt_r  <= cnt_r - SHAMT_W'(1);
                    acc_r  <= shift_acc_s;
                    c_r    <= shift_c_s;
                    v_r    <= 1'b0;
                    z_r    <= is_zero(shift_acc_s);
                    done_r <= (cnt_r == SHAMT_W'(1));
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign req.req_ready     = (state_r == ST_IDLE);
    assign busy_out          = (state_r != ST_IDLE);
    assign done_out          = done_r;
    assign acc_out           = acc_r;
    assign c_flag_out        = c_r;
    assign v_flag_out        = v_r;
    assign z_flag_out        = z_r;
    assign alu_a_out         = acc_r;
    assign alu_b_out         = b_r;
    assign alu_control_out   = ctrl_r;
endmodule

// File: tb/tb_accumulator_ctrl.sv
// Randomized self-checking bench for accumulator_ctrl with a stand-in adder/
// subtractor ALU and an arithmetic reference model of ACC and the flags.
module tb_accumulator_ctrl;
    localparam logic [1:0] C_ALU  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_SHL  = 2'b10;
    localparam logic [1:0] C_SHR  = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] alu_a, alu_b, alu_sum, acc, b_eff;
    logic [2:0] alu_ctl;
    logic [8:0] alu_t;
    logic       alu_carry, alu_ovf, alu_zero;
    logic       c_flag, v_flag, z_flag, busy, done;

    logic [7:0] m_acc;
    logic       m_c, m_v, m_z;
    int         n_checks = 0;
    int         n_fail   = 0;

    accumulator_ctrl_if #(.WIDTH(8), .SHAMT_W(3)) rq ();

    accumulator_ctrl #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk_in          (clk),
        .reset_n_in      (reset_n),
        .req             (rq),
        .alu_a_out       (alu_a),
        .alu_b_out       (alu_b),
        .alu_control_out (alu_ctl),
        .alu_sum_in      (alu_sum),
        .alu_carry_in    (alu_carry),
        .alu_overflow_in (alu_ovf),
        .alu_zero_in     (alu_zero),
        .acc_out         (acc),
        .c_flag_out      (c_flag),
        .v_flag_out      (v_flag),
        .z_flag_out      (z_flag),
        .busy_out        (busy),
        .done_out        (done)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: ctrl bit0 selects add (0) or subtract (1)
    always_comb begin
        b_eff     = alu_ctl[0] ? ~alu_b : alu_b;
        alu_t     = {1'b0, alu_a} + {1'b0, b_eff} + {8'h00, alu_ctl[0]};
        alu_sum   = alu_t[7:0];
        alu_carry = alu_t[8];
        alu_ovf   = (alu_a[7] == b_eff[7]) && (alu_t[7] != alu_a[7]);
        alu_zero  = (alu_t[7:0] == 8'h00);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_acc"}, 32'(acc), 32'(m_acc));
        check_eq({tag, "_c"},   32'(c_flag), 32'(m_c));
        check_eq({tag, "_v"},   32'(v_flag), 32'(m_v));
        check_eq({tag, "_z"},   32'(z_flag), 32'(m_z));
        check_eq({tag, "_alu_a"}, 32'(alu_a), 32'(m_acc));
    endtask

    // Reference: final ACC/flags of one command from plain arithmetic
    task automatic model_apply(input logic [1:0] c, input logic [2:0] ctl,
                               input logic [7:0] op, input logic [2:0] sh);
        logic [8:0] w;
        logic [7:0] orig;
        int         k;
        orig = m_acc;
        k    = int'(sh);
        case (c)
            C_ALU: begin
                if (!ctl[0]) begin
                    w     = {1'b0, orig} + {1'b0, op};
                    m_c   = w[8];
                    m_acc = w[7:0];
                    m_v   = (orig[7] == op[7]) && (m_acc[7] != orig[7]);
                end else begin
                    m_c   = (orig >= op);
                    m_acc = orig - op;
                    m_v   = (orig[7] != op[7]) && (m_acc[7] != orig[7]);
                end
                m_z = (m_acc == 8'h00);
            end
            C_LOAD: begin
                m_acc = op;
                m_z   = (op == 8'h00);
            end
            default: begin
                if (k != 0) begin
                    if (c == C_SHL) begin
                        m_c   = orig[8-k];
                        m_acc = 8'(orig << k);
                    end else begin
                        m_c   = orig[k-1];
                        m_acc = orig >> k;
                    end
                    m_v = 1'b0;
                    m_z = (m_acc == 8'h00);
                end
            end
        endcase
    endtask

    // Issue one command from a post-edge point; returns just after its retire edge
    task automatic do_cmd(input logic [1:0] c, input logic [2:0] ctl,
                          input logic [7:0] op, input logic [2:0] sh);
        int         lat;
        logic [7:0] orig;
        logic [7:0] step;
        check_eq("ready_pre", 32'(rq.req_ready), 32'd1);
        rq.req_valid = 1'b1;
        rq.cmd       = c;
        rq.alu_ctrl  = ctl;
        rq.operand   = op;
        rq.shamt     = sh;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        rq.cmd       = 2'($urandom);
        rq.operand   = 8'($urandom);
        rq.shamt     = 3'($urandom);
        rq.alu_ctrl  = 3'($urandom);
        orig = m_acc;
        lat  = (c[1] && (sh != 3'd0)) ? int'(sh) : 1;
        for (int i = 1; i <= lat; i++) begin
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("ready_busy", 32'(rq.req_ready), 32'd0);
            check_eq("done_early", 32'(done), 32'd0);
            @(posedge clk); #1;
            if (i < lat) begin
                step = (c == C_SHL) ? 8'(orig << i) : (orig >> i);
                check_eq("shift_step", 32'(acc), 32'(step));
            end
        end
        model_apply(c, ctl, op, sh);
        check_eq("done", 32'(done), 32'd1);
        check_eq("ready_post", 32'(rq.req_ready), 32'd1);
        check_state("result");
    endtask

    initial begin
        reset_n      = 1'b0;
        rq.req_valid = 1'b0;
        rq.cmd       = 2'b00;
        rq.alu_ctrl  = 3'b000;
        rq.operand   = 8'h00;
        rq.shamt     = 3'd0;
        m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        check_eq("reset_ready", 32'(rq.req_ready), 32'd1);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_b", 32'(alu_b), 32'd0);
        check_eq("reset_ctl", 32'(alu_ctl), 32'd0);
        reset_n = 1'b1;

        do_cmd(C_LOAD, 3'b000, 8'h7F, 3'd0);
        do_cmd(C_ALU,  3'b000, 8'h01, 3'd0);
        check_eq("t1_acc", 32'(acc), 32'h80);
        check_eq("t1_cvz", 32'({c_flag, v_flag, z_flag}), 32'b010);

        do_cmd(C_LOAD, 3'b000, 8'h35, 3'd0);
        do_cmd(C_ALU,  3'b001, 8'h35, 3'd0);
        check_eq("t2_acc", 32'(acc), 32'h00);
        check_eq("t2_cvz", 32'({c_flag, v_flag, z_flag}), 32'b101);

        do_cmd(C_LOAD, 3'b000, 8'h81, 3'd0);
        do_cmd(C_SHL,  3'b000, 8'h00, 3'd3);
        check_eq("t3_acc", 32'(acc), 32'h08);
        check_eq("t3_c", 32'(c_flag), 32'd0);
        @(posedge clk); #1;
        check_eq("t3_done_once", 32'(done), 32'd0);

        do_cmd(C_LOAD, 3'b000, 8'h01, 3'd0);
        do_cmd(C_SHR,  3'b000, 8'h00, 3'd1);
        check_eq("t4_acc", 32'(acc), 32'h00);
        check_eq("t4_cvz", 32'({c_flag, v_flag, z_flag}), 32'b101);
        do_cmd(C_SHR,  3'b000, 8'h00, 3'd0);
        check_eq("t4_noop_cvz", 32'({c_flag, v_flag, z_flag}), 32'b101);

        // Valid held high with a LOAD while a SHL 7 is running
        do_cmd(C_LOAD, 3'b000, 8'hC3, 3'd0);
        rq.req_valid = 1'b1; rq.cmd = C_SHL; rq.shamt = 3'd7; rq.operand = 8'h11;
        @(posedge clk); #1;
        rq.cmd = C_LOAD; rq.operand = 8'h5A; rq.shamt = 3'd2;
        for (int i = 1; i <= 7; i++) begin
            check_eq("t5_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            if (i < 7) check_eq("t5_step", 32'(acc), 32'(8'(8'hC3 << i)));
        end
        model_apply(C_SHL, 3'b000, 8'h11, 3'd7);
        check_eq("t5_done", 32'(done), 32'd1);
        check_state("t5_shift");
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        check_eq("t5_load_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        model_apply(C_LOAD, 3'b000, 8'h5A, 3'd0);
        check_eq("t5_load_done", 32'(done), 32'd1);
        check_state("t5_load");

        // Reset mid-shift
        do_cmd(C_LOAD, 3'b000, 8'hFF, 3'd0);
        rq.req_valid = 1'b1; rq.cmd = C_SHL; rq.shamt = 3'd5;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_acc = 8'h00; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
        check_state("t6");
        check_eq("t6_ready", 32'(rq.req_ready), 32'd1);
        check_eq("t6_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check_eq("t6_done_after", 32'(done), 32'd0);
        check_eq("t6_acc_after", 32'(acc), 32'd0);

        // Randomized command stream, mixed back-to-back and idle gaps
        for (int n = 0; n < 150; n++) begin
            do_cmd(2'($urandom), 3'($urandom), 8'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check_eq("idle_done", 32'(done), 32'd0);
                check_eq("idle_busy", 32'(busy), 32'd0);
                check_state("idle");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
